cache_line_fill: RTL and testbench
==================================

Name: cache_line_fill

Overview:
- Refill engine on the write side of the cache data and tag SRAMs (1-cycle-read, no-reset dual-port arrays).
- On a miss, bursts one line from memory, writes each beat into the data SRAM, then marks the tag valid.
- After reset it sweeps the tag SRAM to all-invalid, because the arrays have no reset of their own.

Parameters:
- word_width, 32, bits per data word.
- index_width, 8, line index bits; tag SRAM depth is 2**index_width.
- tag_width, 18, tag bits stored per line.
- line_words, 4, words per line; power of two, at least 2; off_w = log2(line_words).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fill_req  in  1  start refill; sampled only while fill_ready=1.
- fill_index  in  index_width  line index to refill.
- fill_tag  in  tag_width  tag of missing line.
- fill_ready  out  1  idle, can accept fill_req.
- fill_done  out  1  one-cycle pulse when the tag is committed.
- mem_read  out  1  burst read request.
- mem_address  out  tag_width+index_width+off_w  word address of line base.
- mem_burstcount  out  off_w+1  always line_words.
- mem_waitrequest  in  1  memory stall; request accepted when mem_read=1 and mem_waitrequest=0.
- mem_readdata  in  word_width  returned beat.
- mem_readdatavalid  in  1  beat valid.
- data_wraddress  out  index_width+off_w  data SRAM write address.
- data_wren  out  1  data SRAM write enable.
- data_data  out  word_width  data SRAM write data.
- tag_wraddress  out  index_width  tag SRAM write address.
- tag_wren  out  1  tag SRAM write enable.
- tag_data  out  tag_width+1  {valid, tag}.

Behaviour:
- All outputs registered. States: CLEAR, IDLE, REQ, RECV, COMMIT.
- Reset:
  - State CLEAR, clear counter 0, beat counter 0.
  - fill_ready, fill_done, mem_read, data_wren and tag_wren are 0.
  - Addresses and data outputs are 0.
- CLEAR:
  - tag_wren=1, tag_wraddress=counter, tag_data=0 every cycle.
  - Exactly 2**index_width consecutive writes, addresses 0..2**index_width-1.
  - Then IDLE; fill_ready=1 on the cycle after the last clear write.
- IDLE:
  - fill_ready=1.
  - On fill_req, latch index and tag, go to REQ; fill_ready=0 from the next cycle.
  - fill_req while not ready is ignored (no queueing).
- REQ:
  - mem_read=1, mem_address={tag,index,off_w'0}, mem_burstcount=line_words.
  - All three held stable while mem_waitrequest=1.
  - On the accept cycle, go to RECV; mem_read=0 from the next cycle; exactly one request per fill.
- Beats:
  - Counted whenever mem_readdatavalid=1 in REQ (including the accept cycle) or RECV; ignored in every other state.
  - Beat k (0-based) at cycle T produces, at T+1: data_wren=1, data_wraddress={index,k}, data_data=beat.
  - Gaps between beats are allowed; data_wren=0 in gap cycles.
- COMMIT:
  - Entered after beat line_words-1.
  - Last beat at T, last data write at T+1, then at T+2: tag_wren=1, tag_wraddress=index, tag_data={1,tag}, fill_done=1.
  - IDLE at T+3 with fill_ready=1.
  - The tag is never written valid before every data word of the line is written.
- Counter wrap: the beat counter is off_w+1 bits and stops at line_words. The clear counter is index_width+1 bits.
- Reset mid-operation:
  - Aborts the fill; no tag write for the aborted line.
  - mem_read=0 from the next edge; CLEAR sweep restarts from 0.
  - Late beats are ignored.
  - The memory is reset together with this block.
- Consumers must not treat the line as a hit before fill_done; the SRAM returns old data on read-during-write.

Test Plan:
- Reset with index_width=3 -> tag writes to addresses 0..7, tag_data=0, one per cycle for 8 cycles; fill_ready=1 on the 9th cycle; no data_wren.
- Fill with line_words=4, index=5, tag=0x2A, beats 0xA0..0xA3 back-to-back -> mem_address=(0x2A<<5)|(5<<2)=0x554, burstcount=4; data writes to 20,21,22,23 with 0xA0..0xA3; tag write at 5 with {1,0x2A} and fill_done 2 cycles after the last beat.
- mem_waitrequest=1 for 3 cycles -> mem_read, mem_address and burstcount stable for 4 cycles, single accept, mem_read=0 afterwards.
- Beats with 2-cycle gaps -> data_wren only the cycle after each valid; correct addresses; tag commit only after the 4th write.
- rst asserted after 2 beats -> no tag_wren with valid=1; mem_read=0; full CLEAR sweep repeats; subsequent beats cause no writes.
- fill_req during RECV, and readdatavalid pulses in IDLE -> no new request, no SRAM writes, fill_ready unaffected.

Source files
------------

// File: rtl/cache_line_fill_if.sv
// Bundle of refill request, memory burst read, and data/tag SRAM write-port signals.
// The refill engine drives through the master modport; the slave modport is the environment.
interface cache_line_fill_if #(
  parameter int unsigned word_width  = 32,
  parameter int unsigned index_width = 8,
  parameter int unsigned tag_width   = 18,
  parameter int unsigned line_words  = 4
);
  localparam int unsigned off_w = $clog2(line_words);

  logic                                 fill_req;
  logic [index_width-1:0]               fill_index;
  logic [tag_width-1:0]                 fill_tag;
  logic                                 fill_ready;
  logic                                 fill_done;

  logic                                 mem_read;
  logic [tag_width+index_width+off_w-1:0] mem_address;
  logic [off_w:0]                       mem_burstcount;
  logic                                 mem_waitrequest;
  logic [word_width-1:0]                mem_readdata;
  logic                                 mem_readdatavalid;

  logic [index_width+off_w-1:0]         data_wraddress;
  logic                                 data_wren;
  logic [word_width-1:0]                data_data;

  logic [index_width-1:0]               tag_wraddress;
  logic                                 tag_wren;
  logic [tag_width:0]                   tag_data;

  modport master (
    input  fill_req, fill_index, fill_tag, mem_waitrequest, mem_readdata, mem_readdatavalid,
    output fill_ready, fill_done, mem_read, mem_address, mem_burstcount,
    output data_wraddress, data_wren, data_data, tag_wraddress, tag_wren, tag_data
  );

  modport slave (
    output fill_req, fill_index, fill_tag, mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  fill_ready, fill_done, mem_read, mem_address, mem_burstcount,
    input  data_wraddress, data_wren, data_data, tag_wraddress, tag_wren, tag_data
  );
endinterface

// File: rtl/cache_line_fill.sv
// Cache refill engine: sweeps the tag SRAM invalid after reset, then bursts missing lines
// from memory into the data SRAM and commits the tag only after the whole line is written.
module cache_line_fill #(
  parameter int unsigned word_width  = 32,
  parameter int unsigned index_width = 8,
  parameter int unsigned tag_width   = 18,
  parameter int unsigned line_words  = 4
) (
  input logic              clk,
  input logic              rst,
  cache_line_fill_if.master bus
);
  localparam int unsigned off_w = $clog2(line_words);
  localparam logic [index_width:0] clr_last  = (index_width+1)'((1 << index_width) - 1);
  localparam logic [off_w:0]       beat_full = (off_w+1)'(line_words);
  localparam logic [off_w:0]       beat_last = (off_w+1)'(line_words - 1);

  typedef enum logic [2:0] {StClear, StIdle, StReq, StRecv, StCommit} state_e;

  state_e                   state_q, state_d;
  logic [index_width:0]     clr_q, clr_d;
  logic [off_w:0]           beat_q, beat_d;
  logic [index_width-1:0]   idx_q, idx_d;
  logic [tag_width-1:0]     tag_q, tag_d;

  logic                     fill_ready_q, fill_ready_d;
  logic                     fill_done_q, fill_done_d;
  logic                     mem_read_q, mem_read_d;
  logic [tag_width+index_width+off_w-1:0] mem_address_q, mem_address_d;
  logic [off_w:0]           mem_burstcount_q, mem_burstcount_d;
  logic [index_width+off_w-1:0] data_wraddress_q, data_wraddress_d;
  logic                     data_wren_q, data_wren_d;
  logic [word_width-1:0]    data_data_q, data_data_d;
  logic [index_width-1:0]   tag_wraddress_q, tag_wraddress_d;
  logic                     tag_wren_q, tag_wren_d;
  logic [tag_width:0]       tag_data_q, tag_data_d;

  logic accept_fill, beat_ok, last_beat;

  // fill_ready_q gates acceptance so a request in the first IDLE cycle is not taken early
  assign accept_fill = (state_q == StIdle) && fill_ready_q && bus.fill_req;
  assign beat_ok     = bus.mem_readdatavalid && ((state_q == StReq) || (state_q == StRecv)) &&
                       (beat_q != beat_full);
  assign last_beat   = beat_ok && (beat_q == beat_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StClear;
      clr_q            <= '0;
      beat_q           <= '0;
      idx_q            <= '0;
      tag_q            <= '0;
      fill_ready_q     <= 1'b0;
      fill_done_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_burstcount_q <= '0;
      data_wraddress_q <= '0;
      data_wren_q      <= 1'b0;
      data_data_q      <= '0;
      tag_wraddress_q  <= '0;
      tag_wren_q       <= 1'b0;
      tag_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      clr_q            <= clr_d;
      beat_q           <= beat_d;
      idx_q            <= idx_d;
      tag_q            <= tag_d;
      fill_ready_q     <= fill_ready_d;
      fill_done_q      <= fill_done_d;
      mem_read_q       <= mem_read_d;
      mem_address_q    <= mem_address_d;
      mem_burstcount_q <= mem_burstcount_d;
      data_wraddress_q <= data_wraddress_d;
      data_wren_q      <= data_wren_d;
      data_data_q      <= data_data_d;
      tag_wraddress_q  <= tag_wraddress_d;
      tag_wren_q       <= tag_wren_d;
      tag_data_q       <= tag_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    beat_d  = beat_ok ? beat_q + 1'b1 : beat_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    unique case (state_q)
      StClear: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == clr_last) state_d = StIdle;
      end
      StIdle: begin
        if (accept_fill) begin
          state_d = StReq;
          idx_d   = bus.fill_index;
          tag_d   = bus.fill_tag;
          beat_d  = '0;
        end
      end
      StReq: begin
        if (!bus.mem_waitrequest) state_d = last_beat ? StCommit : StRecv;
      end
      // All beats may already have arrived while the request was still stalled
      StRecv: begin
        if (last_beat || (beat_q == beat_full)) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StClear;
    endcase
  end

  always_comb begin
    fill_ready_d     = (state_q == StIdle) && !accept_fill;
    fill_done_d      = (state_q == StCommit);
    mem_read_d       = accept_fill || ((state_q == StReq) && bus.mem_waitrequest);
    mem_address_d    = accept_fill ? {bus.fill_tag, bus.fill_index, {off_w{1'b0}}} : mem_address_q;
    mem_burstcount_d = accept_fill ? beat_full : mem_burstcount_q;
    data_wren_d      = beat_ok;
    data_wraddress_d = beat_ok ? {idx_q, beat_q[off_w-1:0]} : data_wraddress_q;
    data_data_d      = beat_ok ? bus.mem_readdata : data_data_q;
    tag_wren_d       = 1'b0;
    tag_wraddress_d  = tag_wraddress_q;
    tag_data_d       = tag_data_q;
    if (state_q == StClear) begin
      tag_wren_d      = 1'b1;
      tag_wraddress_d = clr_q[index_width-1:0];
      tag_data_d      = '0;
    end else if (state_q == StCommit) begin
      tag_wren_d      = 1'b1;
      tag_wraddress_d = idx_q;
      tag_data_d      = {1'b1, tag_q};
    end
  end

  assign bus.fill_ready     = fill_ready_q;
  assign bus.fill_done      = fill_done_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_burstcount = mem_burstcount_q;
  assign bus.data_wraddress = data_wraddress_q;
  assign bus.data_wren      = data_wren_q;
  assign bus.data_data      = data_data_q;
  assign bus.tag_wraddress  = tag_wraddress_q;
  assign bus.tag_wren       = tag_wren_q;
  assign bus.tag_data       = tag_data_q;
endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: the driver acts as memory and pushes expected SRAM
// writes and memory requests; a negedge monitor pops and compares whenever the DUT writes.
module tb_cache_line_fill;
  localparam int unsigned WW = 32;
  localparam int unsigned IW = 3;
  localparam int unsigned TW = 18;
  localparam int unsigned LW = 4;
  localparam int unsigned OW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_line_fill_if #(.word_width(WW), .index_width(IW), .tag_width(TW), .line_words(LW)) bus();

  cache_line_fill #(.word_width(WW), .index_width(IW), .tag_width(TW), .line_words(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    longint unsigned addr;
    longint unsigned data;
    int              cyc;
  } ev_t;

  ev_t             dq[$];
  ev_t             tq[$];
  longint unsigned rq[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkb(input bit ok, input string name, input longint unsigned act,
                        input longint unsigned exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checkb(act == exp, name, act, exp);
  endtask

  // Monitor
  logic                   prev_stall = 1'b0;
  logic [TW+IW+OW-1:0]    prev_addr  = '0;
  logic [OW:0]            prev_bc    = '0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (prev_stall)
      check("req_hold", {bus.mem_read, bus.mem_address, bus.mem_burstcount},
            {1'b1, prev_addr, prev_bc});
    if (bus.mem_read && !bus.mem_waitrequest) begin
      checkb(rq.size() != 0, "req_expected", rq.size(), 1);
      if (rq.size() != 0) begin
        check("req_addr", bus.mem_address, rq.pop_front());
        check("req_burst", bus.mem_burstcount, LW);
      end
    end
    prev_stall = bus.mem_read && bus.mem_waitrequest && !rst;
    prev_addr  = bus.mem_address;
    prev_bc    = bus.mem_burstcount;

    if (bus.data_wren) begin
      checkb(dq.size() != 0, "data_expected", dq.size(), 1);
      if (dq.size() != 0) begin
        e = dq.pop_front();
        check("data_addr", bus.data_wraddress, e.addr);
        check("data_word", bus.data_data, e.data);
        check("data_cycle", cyc, e.cyc);
      end
    end

    if (bus.tag_wren) begin
      checkb(tq.size() != 0, "tag_expected", tq.size(), 1);
      if (tq.size() != 0) begin
        e = tq.pop_front();
        check("tag_addr", bus.tag_wraddress, e.addr);
        check("tag_data", bus.tag_data, e.data);
        check("tag_cycle", cyc, e.cyc);
        check("fill_done", bus.fill_done, e.data >> TW);
      end
    end else if (bus.fill_done) begin
      checkb(bus.tag_wren, "done_without_tag", bus.tag_wren, 1);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int exp_cyc, input string name);
    int n = 0;
    while (!bus.fill_ready && n < 40) begin
      adv();
      n++;
    end
    check(name, bus.fill_ready ? longint'(cyc) : 64'hdead_0000, exp_cyc);
  endtask

  task automatic do_reset(input int cycles, input bit late_beats);
    int r;
    rst = 1'b1;
    bus.fill_req = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_waitrequest = 1'b0;
    repeat (cycles) adv();
    check("reset_outputs", {bus.fill_ready, bus.fill_done, bus.mem_read, bus.data_wren,
                            bus.tag_wren, bus.mem_address, bus.data_wraddress, bus.tag_data}, 0);
    rst = 1'b0;
    r = cyc;
    for (int k = 0; k < (1 << IW); k++) tq.push_back('{longint'(k), 64'd0, r + 1 + k});
    if (late_beats) begin
      for (int k = 0; k < 3; k++) begin
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata = $urandom;
        adv();
      end
      bus.mem_readdatavalid = 1'b0;
    end
    wait_ready(r + (1 << IW) + 1, "clear_ready");
  endtask

  task automatic do_fill(input int idx, input int tg, input int waitn, input int gmin,
                         input int gmax, input bit fixed, input bit poke, input int abort_after);
    longint unsigned d;
    int last = 0;
    int g;
    bus.fill_index = IW'(idx);
    bus.fill_tag = TW'(tg);
    bus.fill_req = 1'b1;
    bus.mem_waitrequest = (waitn > 0);
    rq.push_back(longint'(tg) * (1 << (IW + OW)) + longint'(idx) * LW);
    adv();
    bus.fill_req = 1'b0;
    check("ready_drop", bus.fill_ready, 0);
    check("req_issue", bus.mem_read, 1);
    repeat (waitn) adv();
    bus.mem_waitrequest = 1'b0;
    for (int k = 0; k < LW; k++) begin
      g = $urandom_range(gmax, gmin);
      repeat (g) adv();
      d = fixed ? 64'hA0 + k : longint'($urandom);
      bus.mem_readdatavalid = 1'b1;
      bus.mem_readdata = WW'(d);
      dq.push_back('{longint'(idx * LW + k), d, cyc + 1});
      last = cyc;
      if (poke && k == 1) begin
        bus.fill_req = 1'b1;
        bus.fill_index = IW'(idx ^ 1);
        check("ready_busy", bus.fill_ready, 0);
      end
      adv();
      bus.mem_readdatavalid = 1'b0;
      bus.fill_req = 1'b0;
      if (k + 1 == abort_after) begin
        do_reset(2, 1'b1);
        return;
      end
    end
    tq.push_back('{longint'(idx), (longint'(1) << TW) | longint'(tg), last + 2});
    wait_ready(last + 3, "fill_ready");
  endtask

  initial begin
    bus.fill_req = 1'b0;
    bus.fill_index = '0;
    bus.fill_tag = '0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = '0;
    bus.mem_readdatavalid = 1'b0;

    do_reset(3, 1'b0);
    do_fill(5, 'h2A, 0, 0, 0, 1'b1, 1'b0, 0);
    do_fill(2, 'h3_1234, 3, 0, 1, 1'b0, 1'b0, 0);
    do_fill(7, 'h155, 0, 2, 2, 1'b0, 1'b0, 0);

    for (int k = 0; k < 3; k++) begin
      bus.mem_readdatavalid = 1'b1;
      bus.mem_readdata = $urandom;
      adv();
      check("idle_ready", bus.fill_ready, 1);
    end
    bus.mem_readdatavalid = 1'b0;

    do_fill(1, 'h77, 1, 1, 2, 1'b0, 1'b1, 0);
    do_fill(4, 'h99, 0, 0, 1, 1'b0, 1'b0, 2);

    for (int n = 0; n < 8; n++)
      do_fill($urandom_range(7, 0), $urandom_range((1 << TW) - 1, 0), $urandom_range(3, 0),
              0, $urandom_range(2, 0), 1'b0, 1'b0, 0);

    repeat (4) adv();
    check("data_queue_empty", dq.size(), 0);
    check("tag_queue_empty", tq.size(), 0);
    check("req_queue_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end
endmodule
